router_src_arbiter: RTL and testbench

//  Round-robin arbiter that shares the router's single byte-serial input (pkt_valid/data_in, busy) among

---
 rtl/router_src_arbiter.sv | 178 +++++++++++++++++
 tb/tb_router_src_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_src_arbiter.sv
// Round-robin arbiter sharing the router's byte-serial input among three packet sources.
// Optional ROUTER_ARB_DROP_EN: packets with header addr 2'b11 are consumed and dropped instead of forwarded.
module router_src_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 6
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              src_pkt_valid_0,
  input  logic [DATA_W-1:0] src_data_0,
  input  logic              src_pkt_valid_1,
  input  logic [DATA_W-1:0] src_data_1,
  input  logic              src_pkt_valid_2,
  input  logic [DATA_W-1:0] src_data_2,
  output logic              src_gnt_0,
  output logic              src_gnt_1,
  output logic              src_gnt_2,
  output logic              src_stall_0,
  output logic              src_stall_1,
  output logic              src_stall_2,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_in,
  output logic              len_err,
  output logic              pkt_drop
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    HDR,
    PAY
`ifdef ROUTER_ARB_DROP_EN
    , DROP
`endif
  } state_t;

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [2:0]        gnt;
  logic [1:0]        gnt_idx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  payload_seen;

  logic [2:0]        req;
  logic [1:0]        pick_idx;
  logic [1:0]        next_ptr;
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              stall_cond;

  assign req = {src_pkt_valid_2, src_pkt_valid_1, src_pkt_valid_0};

  // First requester at or after rr_ptr, wrapping modulo 3.
  always_comb begin
    pick_idx = 2'd0;
    case (rr_ptr)
      2'd0:    pick_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      2'd1:    pick_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      default: pick_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
    endcase
  end

  always_comb begin
    sel_valid = src_pkt_valid_2;
    sel_data  = src_data_2;
    case (gnt_idx)
      2'd0: begin
        sel_valid = src_pkt_valid_0;
        sel_data  = src_data_0;
      end
      2'd1: begin
        sel_valid = src_pkt_valid_1;
        sel_data  = src_data_1;
      end
      default: begin
        sel_valid = src_pkt_valid_2;
        sel_data  = src_data_2;
      end
    endcase
  end

  assign next_ptr = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;

`ifdef ROUTER_ARB_DROP_EN
  // A dropped packet is drained at full rate, so the source never stalls there.
  assign stall_cond = (busy | (state == GRANT)) & (state != DROP);
`else
  assign stall_cond = busy | (state == GRANT);
`endif

  assign src_gnt_0   = gnt[0];
  assign src_gnt_1   = gnt[1];
  assign src_gnt_2   = gnt[2];
  assign src_stall_0 = gnt[0] & stall_cond;
  assign src_stall_1 = gnt[1] & stall_cond;
  assign src_stall_2 = gnt[2] & stall_cond;

`ifndef ROUTER_ARB_DROP_EN
  assign pkt_drop = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      gnt          <= '0;
      gnt_idx      <= '0;
      cnt          <= '0;
      payload_seen <= '0;
      pkt_valid    <= 1'b0;
      data_in      <= '0;
      len_err      <= 1'b0;
`ifdef ROUTER_ARB_DROP_EN
      pkt_drop     <= 1'b0;
`endif
    end else begin
      len_err <= 1'b0;
`ifdef ROUTER_ARB_DROP_EN
      pkt_drop <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!busy && (|req)) begin
            gnt     <= 3'b001 << pick_idx;
            gnt_idx <= pick_idx;
            state   <= GRANT;
          end
        end
        GRANT: state <= HDR;
        HDR: begin
          if (!busy) begin
`ifdef ROUTER_ARB_DROP_EN
            if (sel_data[1:0] == 2'b11) begin
              state <= DROP;
            end else
`endif
            begin
              data_in      <= sel_data;
              pkt_valid    <= 1'b1;
              cnt          <= sel_data[DATA_W-1:2];
              payload_seen <= '0;
              state        <= PAY;
            end
          end
        end
        PAY: begin
          if (!busy) begin
            data_in <= sel_data;
            if (sel_valid) begin
              pkt_valid <= 1'b1;
              if (payload_seen != '1)
                payload_seen <= payload_seen + CNT_W'(1);
            end else begin
              pkt_valid <= 1'b0;
              gnt       <= '0;
              rr_ptr    <= next_ptr;
              len_err   <= (payload_seen != cnt);
              state     <= IDLE;
            end
          end
        end
`ifdef ROUTER_ARB_DROP_EN
        DROP: begin
          if (!sel_valid) begin
            gnt      <= '0;
            rr_ptr   <= next_ptr;
            pkt_drop <= 1'b1;
            state    <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_src_arbiter.sv
// Randomized scoreboard bench for router_src_arbiter (default build, drop feature disabled).
module tb_router_src_arbiter;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       busy = 1'b0;
  logic       sv [3];
  logic [7:0] sd [3];
  logic [2:0] gnt;
  logic [2:0] stall;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       len_err;
  logic       pkt_drop;

  router_src_arbiter #(.DATA_W(8), .CNT_W(6)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .src_pkt_valid_0(sv[0]),
    .src_data_0     (sd[0]),
    .src_pkt_valid_1(sv[1]),
    .src_data_1     (sd[1]),
    .src_pkt_valid_2(sv[2]),
    .src_data_2     (sd[2]),
    .src_gnt_0      (gnt[0]),
    .src_gnt_1      (gnt[1]),
    .src_gnt_2      (gnt[2]),
    .src_stall_0    (stall[0]),
    .src_stall_1    (stall[1]),
    .src_stall_2    (stall[2]),
    .busy           (busy),
    .pkt_valid      (pkt_valid),
    .data_in        (data_in),
    .len_err        (len_err),
    .pkt_drop       (pkt_drop)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned src;
    logic [7:0]  data;
    logic        pv;
    logic        lerr;
  } exp_t;

  exp_t        exp_q [$];
  logic [7:0]  pk [3][$];
  int          checks = 0;
  int          failures = 0;
  int unsigned ptr_model = 0;
  int unsigned busy_pct = 0;
  bit          mon_en = 1'b0;
  bit          mon_prime = 1'b0;
  bit          hs_prev = 1'b0;
  int unsigned hs_src_prev = 0;
  logic [7:0]  last_data = '0;
  logic        last_pv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      busy = (busy_pct != 0) && ($urandom_range(99) < busy_pct);
    end
  end

  // Monitor: an accepted source byte must appear on the outputs one clock later;
  // in all other cycles the router-side outputs must hold.
  always @(negedge clock) begin
    if (mon_en) begin
      if (mon_prime) begin
        mon_prime = 1'b0;
      end else if (hs_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(data_in), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("owner", hs_src_prev, e.src);
          chk("data_in", 32'(data_in), 32'(e.data));
          chk("pkt_valid", 32'(pkt_valid), 32'(e.pv));
          chk("len_err", 32'(len_err), 32'(e.lerr));
        end
      end else begin
        chk("hold_data", 32'(data_in), 32'(last_data));
        chk("hold_pv", 32'(pkt_valid), 32'(last_pv));
        chk("len_err_idle", 32'(len_err), 32'd0);
      end
      chk("pkt_drop_tied", 32'(pkt_drop), 32'd0);
      chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      last_data = data_in;
      last_pv   = pkt_valid;
      hs_prev   = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (gnt[k] && !stall[k]) begin
          hs_prev     = 1'b1;
          hs_src_prev = k;
        end
      end
    end
  end

  task automatic make_pkt(input int unsigned k, input logic [7:0] hdr, input int unsigned npay);
    pk[k].delete();
    pk[k].push_back(hdr);
    for (int unsigned i = 0; i < npay; i++) pk[k].push_back(8'($urandom_range(255)));
    pk[k].push_back(8'($urandom_range(255)));
  endtask

  task automatic drive_pkt(input int unsigned k, input logic [7:0] b [$]);
    for (int unsigned i = 0; i < b.size(); i++) begin
      int unsigned n;
      sv[k] = (i != b.size() - 1);
      sd[k] = b[i];
      n = 0;
      @(negedge clock);
      while (!(gnt[k] && !stall[k])) begin
        if (n == 300) begin
          chk("accept_timeout", k, 32'hFFFF_FFFF);
          sv[k] = 1'b0;
          return;
        end
        n++;
        @(negedge clock);
      end
      @(posedge clock);
      #1;
    end
    sv[k] = 1'b0;
    sd[k] = 8'($urandom_range(255));
  endtask

  // Reference: sources present together are served in cyclic order from the
  // round-robin pointer, which moves past each source as its packet completes.
  task automatic run_round(input logic [2:0] subset);
    int unsigned p;
    p = ptr_model;
    for (int unsigned i = 0; i < 3; i++) begin
      int unsigned s;
      s = (p + i) % 3;
      if (subset[s]) begin
        int unsigned last;
        int unsigned npay;
        logic        lerr;
        last = pk[s].size() - 1;
        npay = last - 1;
        lerr = ((npay > 63 ? 63 : npay) != int'(pk[s][0][7:2]));
        for (int unsigned j = 0; j <= last; j++) begin
          exp_t e;
          e.src  = s;
          e.data = pk[s][j];
          e.pv   = (j != last);
          e.lerr = (j == last) ? lerr : 1'b0;
          exp_q.push_back(e);
        end
        ptr_model = (s + 1) % 3;
      end
    end
    fork
      if (subset[0]) drive_pkt(0, pk[0]);
      if (subset[1]) drive_pkt(1, pk[1]);
      if (subset[2]) drive_pkt(2, pk[2]);
    join
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b0;
      sd[k] = '0;
    end
    @(posedge clock);
    #3 resetn = 1'b0;
    #1;
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_pkt_drop", 32'(pkt_drop), 32'd0);
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    mon_prime = 1'b1;
    mon_en    = 1'b1;

    // Simultaneous requests after reset, two rounds
    for (int r = 0; r < 2; r++) begin
      for (int unsigned k = 0; k < 3; k++) make_pkt(k, 8'h15, 5);
      run_round(3'b111);
    end
    // Single source, length 5, addr 01
    make_pkt(1, 8'h15, 5);
    run_round(3'b010);
    // Short payload: len 5 with only 3 bytes
    make_pkt(0, 8'h15, 3);
    run_round(3'b001);
    // addr 11 forwarded in this build
    make_pkt(2, 8'h17, 5);
    run_round(3'b100);
    // Zero-length header
    make_pkt(1, 8'h02, 0);
    run_round(3'b010);
    // Same packet under back-pressure
    busy_pct = 40;
    make_pkt(1, 8'h15, 5);
    run_round(3'b010);

    for (int r = 0; r < 40; r++) begin
      logic [2:0] subset;
      subset = 3'($urandom_range(1, 7));
      busy_pct = $urandom_range(0, 50);
      for (int unsigned k = 0; k < 3; k++) begin
        if (subset[k]) begin
          int unsigned len;
          int unsigned npay;
          len  = $urandom_range(0, 6);
          npay = ($urandom_range(3) != 0) ? len : $urandom_range(0, 8);
          make_pkt(k, {6'(len), 2'($urandom_range(3))}, npay);
        end
      end
      run_round(subset);
    end

    // Reset in the middle of a src2 packet
    repeat (3) @(negedge clock);
    chk("drain_before_reset", exp_q.size(), 0);
    mon_en   = 1'b0;
    busy_pct = 0;
    @(posedge clock);
    #1;
    sv[2] = 1'b1;
    sd[2] = 8'h15;
    begin
      int unsigned n;
      n = 0;
      @(negedge clock);
      while (!gnt[2] && n < 50) begin
        n++;
        @(negedge clock);
      end
      chk("src2_granted", 32'(gnt[2]), 32'd1);
    end
    repeat (3) @(negedge clock);
    chk("mid_pkt_valid", 32'(pkt_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_gnt2", 32'(gnt[2]), 32'd0);
    chk("abort_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("abort_data_in", 32'(data_in), 32'd0);
    chk("abort_stall", 32'(stall), 32'd0);
    sv[2] = 1'b0;
    exp_q.delete();
    ptr_model = 0;
    @(posedge clock);
    #2 resetn = 1'b1;
    hs_prev   = 1'b0;
    mon_prime = 1'b1;
    mon_en    = 1'b1;
    make_pkt(0, 8'h0D, 3);
    make_pkt(2, 8'h09, 2);
    run_round(3'b101);

    begin
      int unsigned n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        n++;
        @(negedge clock);
      end
    end
    repeat (2) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
